// File: rtl/collision_pkg.sv
// Shared definitions for the collision arbiter: colour width, the default
// transparent colour code, the default coordinate type and a small opacity helper.
package collision_pkg;

    localparam int COLOR_W     = 8;
    localparam int COORD_W_DEF = 11;

    localparam logic [COLOR_W-1:0] MASK_VALUE_DEF = 8'h62;

    typedef logic [COORD_W_DEF-1:0] coord_t;

    // A pixel takes part in a collision only when it is not the transparent code.
    function automatic logic is_opaque(input logic [COLOR_W-1:0] color,
                                       input logic [COLOR_W-1:0] mask);
        return (color != mask);
    endfunction

endpackage

// File: rtl/collision_arbiter_n_cooldown.sv
// Per-layer cooldown counter: after a layer is reported it stays suppressed for
// COOLDOWN_FRAMES further frame boundaries. A load wins over a decrement.
module collision_cooldown_ctr #(
    parameter int COOLDOWN_FRAMES = 2,
    parameter int CNT_W           = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic load,
    input  logic dec,
    output logic active
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: reload on report, otherwise saturating decrement per frame.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = CNT_W'(COOLDOWN_FRAMES);
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign active = (cnt_r != {CNT_W{1'b0}});

endmodule

// File: rtl/collision_arbiter_n.sv
// Player/obstacle collision arbiter. Accumulates per-layer hits over a video
// frame, remembers the first colliding pixel, and at each frame boundary
// publishes a held report (minus layers still in cooldown) to a consumer.
module collision_arbiter_n
    import collision_pkg::*;
#(
    parameter int                 NUM_LAYERS      = 4,
    parameter logic [COLOR_W-1:0] MASK_VALUE      = MASK_VALUE_DEF,
    parameter int                 COORD_W         = 11,
    parameter int                 COOLDOWN_FRAMES = 2
) (
    input  logic                                 clk,
    input  logic                                 resetN,
    input  logic                                 frame_start,
    input  logic [COORD_W-1:0]                   pixel_x,
    input  logic [COORD_W-1:0]                   pixel_y,
    input  logic [COLOR_W-1:0]                   player_color,
    input  logic [NUM_LAYERS-1:0][COLOR_W-1:0]   layer_color,
    input  logic [NUM_LAYERS-1:0]                layer_enable,
    input  logic                                 report_ack,
    output logic                                 report_valid,
    output logic [NUM_LAYERS-1:0]                report_hits,
    output logic [COORD_W-1:0]                   hit_x,
    output logic [COORD_W-1:0]                   hit_y,
    output logic                                 overrun
);

    // A zero cooldown still needs a one-bit counter that simply never loads nonzero.
    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic [NUM_LAYERS-1:0] hit_s;
    logic                  any_hit_s;
    logic [NUM_LAYERS-1:0] masked_s;
    logic                  report_load_s;
    logic [NUM_LAYERS-1:0] cd_active_s;
    logic [NUM_LAYERS-1:0] cd_load_s;

    logic [NUM_LAYERS-1:0] acc_r;
    logic                  first_valid_r;
    logic [COORD_W-1:0]    first_x_r;
    logic [COORD_W-1:0]    first_y_r;

    logic                  report_valid_r;
    logic [NUM_LAYERS-1:0] report_hits_r;
    logic [COORD_W-1:0]    hit_x_r;
    logic [COORD_W-1:0]    hit_y_r;
    logic                  overrun_r;

    // Per-layer collision at the current pixel: enabled, and both sprites opaque.
    always_comb begin
        hit_s = {NUM_LAYERS{1'b0}};
        for (int i = 0; i < NUM_LAYERS; i++) begin
            hit_s[i] = layer_enable[i]
                     & is_opaque(player_color, MASK_VALUE)
                     & is_opaque(layer_color[i], MASK_VALUE);
        end
    end

    assign any_hit_s     = |hit_s;
    assign masked_s      = acc_r & ~cd_active_s;
    assign report_load_s = frame_start & (|masked_s);
    assign cd_load_s     = masked_s & {NUM_LAYERS{frame_start}};

    // One cooldown counter per layer; every frame boundary counts it down.
    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_cd
        collision_cooldown_ctr #(
            .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
            .CNT_W           (CNT_W)
        ) u_cd (
            .clk    (clk),
            .resetN (resetN),
            .load   (cd_load_s[g]),
            .dec    (frame_start),
            .active (cd_active_s[g])
        );
    end

    // Frame accumulator and first-hit capture; the frame_start pixel opens the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_r         <= {NUM_LAYERS{1'b0}};
            first_valid_r <= 1'b0;
            first_x_r     <= {COORD_W{1'b0}};
            first_y_r     <= {COORD_W{1'b0}};
        end else if (frame_start) begin
            acc_r         <= hit_s;
            first_valid_r <= any_hit_s;
            if (any_hit_s) begin
                first_x_r <= pixel_x;
                first_y_r <= pixel_y;
            end
        end else begin
            acc_r <= acc_r | hit_s;
            if (!first_valid_r && any_hit_s) begin
                first_valid_r <= 1'b1;
                first_x_r     <= pixel_x;
                first_y_r     <= pixel_y;
            end
        end
    end

    // Report holding register with ack handshake and sticky overrun flag.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            report_valid_r <= 1'b0;
            report_hits_r  <= {NUM_LAYERS{1'b0}};
            hit_x_r        <= {COORD_W{1'b0}};
            hit_y_r        <= {COORD_W{1'b0}};
            overrun_r      <= 1'b0;
        end else if (report_load_s) begin
            report_valid_r <= 1'b1;
            report_hits_r  <= masked_s;
            hit_x_r        <= first_x_r;
            hit_y_r        <= first_y_r;
            if (report_valid_r && !report_ack) begin
                overrun_r <= 1'b1;
            end
        end else if (report_valid_r && report_ack) begin
            report_valid_r <= 1'b0;
        end
    end

    assign report_valid = report_valid_r;
    assign report_hits  = report_hits_r;
    assign hit_x        = hit_x_r;
    assign hit_y        = hit_y_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_collision_arbiter_n.sv
// Self-checking bench for collision_arbiter_n: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a frame-level model.
module tb_collision_arbiter_n;
    import collision_pkg::*;

    localparam int         NL   = 4;
    localparam int         CD   = 2;
    localparam int         CW   = 11;
    localparam logic [7:0] MASK = 8'h62;

    typedef logic [NL-1:0][7:0] lc_t;
    typedef struct { int x; int y; } pt_t;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          frame_start = 1'b0;
    logic [CW-1:0] pixel_x = '0;
    logic [CW-1:0] pixel_y = '0;
    logic [7:0]    player_color = 8'h00;
    lc_t           layer_color;
    logic [NL-1:0] layer_enable = '0;
    logic          report_ack = 1'b0;
    logic          report_valid;
    logic [NL-1:0] report_hits;
    logic [CW-1:0] hit_x;
    logic [CW-1:0] hit_y;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    // Model state: report as the consumer should see it.
    logic          m_valid = 1'b0;
    logic [NL-1:0] m_hits  = '0;
    int            m_x = 0;
    int            m_y = 0;
    logic          m_ovr = 1'b0;
    logic [NL-1:0] m_acc = '0;
    pt_t           m_pts[$];
    int            fs_count = 0;
    int            last_rep[NL];
    bit            rep_seen[NL];

    collision_arbiter_n #(
        .NUM_LAYERS(NL), .MASK_VALUE(MASK), .COORD_W(CW), .COOLDOWN_FRAMES(CD)
    ) dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .player_color(player_color),
        .layer_color(layer_color), .layer_enable(layer_enable),
        .report_ack(report_ack), .report_valid(report_valid),
        .report_hits(report_hits), .hit_x(hit_x), .hit_y(hit_y), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic lc_t lc_fill(input logic [7:0] c);
        lc_t r;
        for (int i = 0; i < NL; i++) r[i] = c;
        return r;
    endfunction

    function automatic lc_t lc_one(input int layer, input logic [7:0] c);
        lc_t r;
        for (int i = 0; i < NL; i++) r[i] = (i == layer) ? c : MASK;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_hits = '0; m_x = 0; m_y = 0; m_ovr = 1'b0; m_acc = '0;
        m_pts.delete();
        for (int i = 0; i < NL; i++) rep_seen[i] = 1'b0;
    endtask

    // Frame-level rules: a layer reported at boundary k is hidden at boundaries k+1..k+CD.
    task automatic model_step();
        logic [NL-1:0] hits;
        logic [NL-1:0] masked;
        hits = '0;
        for (int i = 0; i < NL; i++)
            hits[i] = layer_enable[i] && (player_color != MASK) && (layer_color[i] != MASK);
        if (frame_start) begin
            fs_count++;
            masked = '0;
            for (int i = 0; i < NL; i++)
                if (m_acc[i] && !(rep_seen[i] && (fs_count - last_rep[i] <= CD))) masked[i] = 1'b1;
            if (masked != '0) begin
                if (m_valid && !report_ack) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_hits  = masked;
                m_x     = m_pts[0].x;
                m_y     = m_pts[0].y;
                for (int i = 0; i < NL; i++)
                    if (masked[i]) begin rep_seen[i] = 1'b1; last_rep[i] = fs_count; end
            end else if (report_ack) begin
                m_valid = 1'b0;
            end
            m_acc = hits;
            m_pts.delete();
        end else begin
            if (report_ack) m_valid = 1'b0;
            m_acc = m_acc | hits;
        end
        if (hits != '0 && m_pts.size() < 64) m_pts.push_back('{x: int'(pixel_x), y: int'(pixel_y)});
    endtask

    // Compare process: update the model on each edge (or async reset) and check all outputs.
    initial begin
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) model_reset();
            else model_step();
            #1;
            chk("valid", report_valid, m_valid);
            chk("hits", report_hits, m_hits);
            chk("hit_x", hit_x, m_x);
            chk("hit_y", hit_y, m_y);
            chk("overrun", overrun, m_ovr);
        end
    end

    task automatic step(input logic fs, input logic ack, input logic [7:0] pc,
                        input lc_t lc, input logic [NL-1:0] en, input int x, input int y);
        frame_start  = fs;
        report_ack   = ack;
        player_color = pc;
        layer_color  = lc;
        layer_enable = en;
        pixel_x      = CW'(x);
        pixel_y      = CW'(y);
        @(negedge clk);
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [3:0] e35;
        layer_color = lc_fill(MASK);
        e35 = 4'b1001;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", report_valid, 1'b0);
        chk("rst_hits", report_hits, 4'h0);
        chk("rst_overrun", overrun, 1'b0);
        resetN = 1'b1;

        // Basic report of layer 1, first hit at (100,200).
        step(1'b1, 1'b0, 8'h10, lc_fill(MASK), 4'hF, 0, 0);
        step(1'b0, 1'b0, 8'h10, lc_one(1, 8'h20), 4'hF, 100, 200);
        step(1'b0, 1'b0, 8'h10, lc_one(1, 8'h20), 4'hF, 101, 200);
        step(1'b0, 1'b0, 8'h10, lc_fill(MASK), 4'hF, 5, 5);
        step(1'b1, 1'b0, 8'h10, lc_fill(MASK), 4'hF, 6, 6);
        chk("d033_valid", report_valid, 1'b1);
        chk("d033_hits", report_hits, 4'b0010);
        chk("d033_x", hit_x, 100);
        chk("d033_y", hit_y, 200);
        step(1'b0, 1'b1, 8'h10, lc_fill(MASK), 4'hF, 7, 7);
        chk("d033_ack", report_valid, 1'b0);

        // Transparent player over opaque layers: nothing reported.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, MASK, lc_fill(8'h33), 4'hF, i, 1);
        step(1'b1, 1'b0, MASK, lc_fill(8'h33), 4'hF, 9, 1);
        chk("d034_valid", report_valid, 1'b0);

        // Layer 2 hits every frame with ack: cooldown hides frames 1 and 2.
        for (int f = 0; f < 5; f++) begin
            if (f < 4) begin
                step(1'b1, 1'b0, 8'h10, lc_one(2, 8'h44), 4'hF, f, 7);
                if (f > 0) chk("d035_valid", report_valid, e35[f-1]);
                step(1'b0, 1'b1, 8'h10, lc_one(2, 8'h44), 4'hF, f, 8);
                step(1'b0, 1'b1, 8'h10, lc_one(2, 8'h44), 4'hF, f, 9);
            end else begin
                step(1'b1, 1'b0, 8'h10, lc_fill(MASK), 4'hF, 0, 0);
                chk("d035_valid_last", report_valid, e35[3]);
                chk("d035_hits", report_hits, 4'b0100);
            end
        end

        // Two reports without ack: overwrite and overrun.
        step(1'b0, 1'b1, 8'h10, lc_fill(MASK), 4'hF, 1, 1);
        step(1'b0, 1'b0, 8'h10, lc_one(0, 8'h55), 4'hF, 7, 8);
        step(1'b1, 1'b0, 8'h10, lc_fill(MASK), 4'hF, 0, 0);
        chk("d036_first_hits", report_hits, 4'b0001);
        step(1'b0, 1'b0, 8'h10, lc_one(3, 8'h66), 4'hF, 9, 10);
        step(1'b1, 1'b0, 8'h10, lc_fill(MASK), 4'hF, 0, 0);
        chk("d036_hits", report_hits, 4'b1000);
        chk("d036_x", hit_x, 9);
        chk("d036_y", hit_y, 10);
        chk("d036_overrun", overrun, 1'b1);
        step(1'b0, 1'b1, 8'h10, lc_fill(MASK), 4'hF, 1, 1);
        chk("d036_ack", report_valid, 1'b0);

        // Hit on the frame_start pixel belongs to the new frame.
        step(1'b1, 1'b0, 8'h10, lc_one(1, 8'h21), 4'hF, 0, 0);
        step(1'b0, 1'b0, 8'h10, lc_fill(MASK), 4'hF, 3, 3);
        step(1'b1, 1'b0, 8'h10, lc_fill(MASK), 4'hF, 4, 4);
        chk("d037_valid", report_valid, 1'b1);
        chk("d037_hits", report_hits, 4'b0010);
        chk("d037_x", hit_x, 0);
        chk("d037_y", hit_y, 0);

        // Asynchronous reset clears everything without a clock edge.
        #2 resetN = 1'b0;
        #1;
        chk("d038_valid", report_valid, 1'b0);
        chk("d038_hits", report_hits, 4'h0);
        chk("d038_x", hit_x, 0);
        chk("d038_y", hit_y, 0);
        chk("d038_overrun", overrun, 1'b0);
        @(negedge clk);
        resetN = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            lc_t lc;
            for (int i = 0; i < NL; i++)
                lc[i] = ($urandom_range(0, 1) == 0) ? MASK : 8'($urandom);
            if (c == 1500) begin
                #2 resetN = 1'b0;
                @(negedge clk);
                resetN = 1'b1;
            end
            step($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 3) == 0) ? MASK : 8'($urandom),
                 lc, NL'($urandom), int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/collision_arbiter_n.md
COLLISION_ARBITER_N -- requirements
Module: collision_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of obstacle colour layers (1..8).
REQ-002 SHALL have parameter MASK_VALUE, default 8'h62, transparent-pixel colour code.
REQ-003 SHALL have parameter COORD_W, default 11, pixel coordinate width.
REQ-004 SHALL have parameter COOLDOWN_FRAMES, default 2, frames a reported layer is suppressed (0 = no suppression).
REQ-005 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port resetN  in  1  asynchronous active-low reset.
REQ-007 SHALL have port frame_start  in  1  one-cycle pulse marking the first pixel of a frame.
REQ-008 SHALL have port pixel_x / pixel_y  in  COORD_W each  current pixel coordinate.
REQ-009 SHALL have port player_color  in  8  player sprite colour at current pixel.
REQ-010 SHALL have port layer_color  in  NUM_LAYERS x 8  per-layer colour at current pixel.
REQ-011 SHALL have port layer_enable  in  NUM_LAYERS  per-layer collision enable.
REQ-012 SHALL have port report_ack  in  1  consumer acknowledge of report.
REQ-013 SHALL have port report_valid  out  1  frame report pending.
REQ-014 SHALL have port report_hits  out  NUM_LAYERS  per-layer collision flags of last completed frame.
REQ-015 SHALL have port hit_x / hit_y  out  COORD_W each  coordinate of first collision pixel of reported frame.
REQ-016 SHALL have port overrun  out  1  sticky: a report was replaced before ack.

Function
REQ-017 SHALL define hit[i] = layer_enable[i] & (player_color != MASK_VALUE) & (layer_color[i] != MASK_VALUE), combinational per cycle.
REQ-018 SHALL OR hit[] into sticky accumulator acc each cycle of a frame.
REQ-019 SHALL capture pixel_x/pixel_y into first-hit registers on the first cycle of a frame where any hit is 1; later hits SHALL NOT update them.
REQ-020 On frame_start, SHALL transfer acc masked by ~cooldown_active into report_hits, first-hit coordinates into hit_x/hit_y, and set report_valid=1 only if the masked value is nonzero.
REQ-021 On frame_start, SHALL reload acc with that cycle's hit[] (frame_start pixel belongs to the new frame) and re-arm first-hit capture accordingly.
REQ-022 report_valid SHALL remain 1 until the cycle after report_ack=1 is sampled; report_hits/hit_x/hit_y SHALL be stable while report_valid=1 except per REQ-024.
REQ-023 report_ack while report_valid=0 SHALL be ignored.
REQ-024 If frame_start loads a nonzero report while report_valid=1 and report_ack=0, the new report SHALL overwrite, report_valid stays 1, overrun SHALL set to 1.
REQ-025 If frame_start and report_ack coincide, the new report SHALL load, report_valid follows REQ-020, overrun SHALL NOT set.
REQ-026 Per layer, a cooldown counter (width clog2(COOLDOWN_FRAMES+1)) SHALL load COOLDOWN_FRAMES when that layer is reported as 1, decrement by 1 on each later frame_start, saturate at 0; cooldown_active[i] = counter != 0.
REQ-027 A masked-zero frame SHALL leave report_valid, report_hits and hit_x/hit_y unchanged.
REQ-028 overrun SHALL clear only on reset.

Reset
REQ-029 On resetN=0, SHALL immediately clear report_valid, report_hits, hit_x, hit_y, overrun, acc, first-hit flag and all cooldown counters to 0.
REQ-030 After release, the partial frame before the first frame_start SHALL be accumulated and reported normally.

Structure
REQ-031 SHALL place MASK_VALUE default, COLOR_W=8 and the coordinate typedef in shared package collision_pkg.
REQ-032 SHALL instantiate NUM_LAYERS copies of sub-module collision_cooldown_ctr (load, decrement, active output).

Verification (NUM_LAYERS=4, COOLDOWN_FRAMES=2)
REQ-033 Player 8'h10, layer1 8'h20 at (100,200) and (101,200), then frame_start -> report_valid=1, report_hits=4'b0010, hit_x=100, hit_y=200.
REQ-034 Player 8'h62 over all layers opaque for a whole frame -> no report_valid.
REQ-035 Layer2 hits in frames 0..3, acked each frame -> reported after frames 0 and 3 only.
REQ-036 Two reporting frames without ack -> second report visible, overrun=1; ack -> report_valid=0 next cycle.
REQ-037 Hit on frame_start cycle at (0,0) -> counts in new frame, hit_x=0, hit_y=0 at next frame_start.
REQ-038 resetN pulled low while report_valid=1 -> all outputs 0 without a clk edge.
